// File: rtl/unpack_arbiter.sv
// ============================================================================
// Module   : unpack_arbiter
// Purpose  : Round-robin packet arbiter that shares one data_unpack serializer
//            between NUM_SRC word sources. A source owns the serializer from
//            its sop word through its eop word. Non-sop words from sources
//            that are not the owner are accepted and dropped (counted).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module unpack_arbiter #(
  parameter int NUM_SRC    = 4,
  parameter int WORD_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst,        // asynchronous, active low
  input  logic [NUM_SRC-1:0]            src_valid,
  input  logic [NUM_SRC*WORD_WIDTH-1:0] src_data,
  input  logic [NUM_SRC-1:0]            src_sop,
  input  logic [NUM_SRC-1:0]            src_eop,
  output logic [NUM_SRC-1:0]            src_ready,
  output logic                          valid_out,
  output logic [WORD_WIDTH-1:0]         data_out,
  output logic                          sop_out,
  output logic                          eop_out,
  input  logic                          ready_in,
  output logic [NUM_SRC-1:0]            grant,
  output logic                          busy,
  output logic [15:0]                   drop_count
);

  localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  logic [0:0]         state;
  logic [IDX_W-1:0]   gnt_idx;
  logic [IDX_W-1:0]   last_idx;

  logic [NUM_SRC-1:0] owner_mask;
  logic [NUM_SRC-1:0] req;
  logic [NUM_SRC-1:0] drop_vec;
  logic [3:0]         drop_sum;
  logic [16:0]        drop_next;
  logic               xfer_eop;

  logic               found;
  logic [IDX_W-1:0]   winner;
  logic [IDX_W-1:0]   base;
  int                 span;
  int                 j;

  assign busy  = (state == ST_BUSY);
  assign grant = owner_mask;
  assign req   = src_valid & src_sop;

  // One-hot owner mask; empty while idle (and therefore while in reset)
  always_comb begin
    owner_mask = '0;
    if (busy) owner_mask[gnt_idx] = 1'b1;
  end

  // Forward the owner's word to the serializer; all zero while idle
  always_comb begin
    valid_out = 1'b0;
    data_out  = '0;
    sop_out   = 1'b0;
    eop_out   = 1'b0;
    if (busy) begin
      valid_out = src_valid[gnt_idx];
      data_out  = src_data[gnt_idx*WORD_WIDTH +: WORD_WIDTH];
      sop_out   = src_sop[gnt_idx];
      eop_out   = src_eop[gnt_idx];
    end
  end

  // Stray (non-sop) words from non-owners are swallowed; gated off in reset
  assign drop_vec  = src_valid & ~src_sop & ~owner_mask & {NUM_SRC{rst}};
  assign src_ready = (owner_mask & {NUM_SRC{ready_in}}) | drop_vec;
  assign xfer_eop  = valid_out & ready_in & eop_out;

  // Round-robin search: idle scans all sources after last_idx, busy scans the
  // others after the owner (the owner's just-finished packet never re-wins)
  always_comb begin
    found  = 1'b0;
    winner = '0;
    j      = 0;
    base   = busy ? gnt_idx : last_idx;
    span   = busy ? (NUM_SRC - 1) : NUM_SRC;
    for (int k = NUM_SRC; k >= 1; k--) begin
      j = int'(base) + k;
      if (j >= NUM_SRC) j = j - NUM_SRC;
      if ((k <= span) && req[j]) begin
        found  = 1'b1;
        winner = IDX_W'(j);
      end
    end
  end

  // Number of words dropped this cycle and the saturating next count
  always_comb begin
    drop_sum = '0;
    for (int i = 0; i < NUM_SRC; i++) drop_sum = drop_sum + 4'(drop_vec[i]);
    drop_next = {1'b0, drop_count} + 17'(drop_sum);
  end

  // Grant state machine and round-robin pointer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      gnt_idx  <= '0;
      last_idx <= IDX_W'(NUM_SRC - 1);
    end else begin
      case (state)
        ST_IDLE: begin
          if (found) begin
            state    <= ST_BUSY;
            gnt_idx  <= winner;
            last_idx <= winner;
          end
        end
        ST_BUSY: begin
          if (xfer_eop) begin
            if (found) begin
              gnt_idx  <= winner;
              last_idx <= winner;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Saturating discard counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) drop_count <= '0;
    else      drop_count <= drop_next[16] ? 16'hFFFF : drop_next[15:0];
  end

endmodule

`default_nettype wire
